// File: rtl/approx_mac_accum.sv
// rtl/approx_mac_accum.sv - saturating accumulator for approximate multiplier products
// Sums a last-delimited vector of products and hands the result over a registered valid/ready port.
module approx_mac_accum #(
   parameter int PW = 16,
   parameter int AW = 24,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_prod,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_sum,
   output logic [CW-1:0] out_count,
   output logic          out_ovf
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACC  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          out_valid_q, out_valid_d;
   logic [AW-1:0] out_sum_q, out_sum_d;
   logic [CW-1:0] out_count_q, out_count_d;
   logic          out_ovf_q, out_ovf_d;

   logic          in_fire;
   logic          out_fire;
   logic [AW-1:0] acc_base;
   logic [CW-1:0] cnt_base;
   logic          ovf_base;
   logic [AW:0]   sum;
   logic [AW-1:0] acc_n;
   logic [CW-1:0] cnt_n;
   logic          ovf_n;

   assign in_ready = !out_valid_q || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

   // Running state only counts while a vector is open; a fresh vector starts from zero.
   assign acc_base = (state_q == ST_ACC) ? acc_q : '0;
   assign cnt_base = (state_q == ST_ACC) ? cnt_q : '0;
   assign ovf_base = (state_q == ST_ACC) ? ovf_q : 1'b0;

   assign sum   = {1'b0, acc_base} + {{(AW + 1 - PW){1'b0}}, in_prod};
   assign acc_n = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
   assign cnt_n = (cnt_base == {CW{1'b1}}) ? cnt_base : cnt_base + 1'b1;
   assign ovf_n = ovf_base | sum[AW];

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;

      if (out_fire) begin
         out_valid_d = 1'b0;
      end

      if (in_fire) begin
         if (in_last) begin
            out_valid_d = 1'b1;
            out_sum_d   = acc_n;
            out_count_d = cnt_n;
            out_ovf_d   = ovf_n;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = ST_IDLE;
         end else begin
            acc_d   = acc_n;
            cnt_d   = cnt_n;
            ovf_d   = ovf_n;
            state_d = ST_ACC;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_count = out_count_q;
   assign out_ovf   = out_ovf_q;

endmodule
